// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then device-clocked
// shifting of one byte with odd parity, stop bit and ack check; open-drain pull-low enables.
module ps2_host_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       k_clk,
    input  logic       k_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       k_clk_oe,
    output logic       k_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);
    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int RTS_CYC     = 16;
    localparam int INH_W       = $clog2(INHIBIT_CYC + RTS_CYC) + 1;
    localparam int TO_W        = $clog2(TIMEOUT_CYC) + 1;
    localparam int FC_W        = $clog2(FILTER) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t            r_state;
    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_clk_filt;
    logic [FC_W-1:0]   r_fcnt;
    logic              r_fall;
    logic [7:0]        r_data;
    logic              r_par;
    logic [3:0]        r_bit;
    logic [INH_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    // Sync both lines; k_clk level only changes after FILTER consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_fcnt     <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= k_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= k_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 != r_clk_filt) begin
                if (r_fcnt == FC_W'(FILTER - 1)) begin
                    r_clk_filt <= r_clk_s2;
                    r_fcnt     <= '0;
                    r_fall     <= ~r_clk_s2;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_to_cnt  <= '0;
            k_clk_oe  <= 1'b0;
            k_data_oe <= 1'b0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_data    <= tx_data;
                        r_par     <= ~^tx_data;
                        r_cnt     <= '0;
                        k_clk_oe  <= 1'b1;
                        k_data_oe <= 1'b0;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                        r_cnt     <= '0;
                        k_data_oe <= 1'b1;
                        r_state   <= S_RTS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    if (r_cnt == INH_W'(RTS_CYC - 1)) begin
                        k_clk_oe <= 1'b0;
                        r_to_cnt <= '0;
                        r_bit    <= '0;
                        r_state  <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        k_clk_oe  <= 1'b0;
                        k_data_oe <= 1'b0;
                        timeout   <= 1'b1;
                        tx_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_state == S_SEND) begin
                            if (r_fall) begin
                                r_bit <= r_bit + 1'b1;
                                if (r_bit < 4'd8) begin
                                    k_data_oe <= ~r_data[r_bit[2:0]];
                                end else if (r_bit == 4'd8) begin
                                    k_data_oe <= ~r_par;
                                end else begin
                                    k_data_oe <= 1'b0;
                                    r_state   <= S_ACK;
                                end
                            end
                        end else if (r_state == S_ACK) begin
                            if (r_fall) begin
                                if (!r_dat_s2) begin
                                    r_state <= S_WAIT_IDLE;
                                end else begin
                                    ack_err  <= 1'b1;
                                    tx_ready <= 1'b1;
                                    busy     <= 1'b0;
                                    r_state  <= S_IDLE;
                                end
                            end
                        end else if (r_clk_filt && r_dat_s2) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    k_clk_oe  <= 1'b0;
                    k_data_oe <= 1'b0;
                    tx_ready  <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND line model plus a behavioural keyboard that clocks
// frames, records the bits it sees on k_data and acks or nacks the 11th edge.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TO   = 1000;
    localparam int FILT = 8;
    localparam int H    = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       k_clk, k_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, k_clk_oe, k_data_oe, busy, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_nack = 0, n_to = 0;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        int         exp_done;
        int         exp_nack;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    assign k_clk  = ~(k_clk_oe | dev_clk_low);
    assign k_data = ~(k_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ(1_000_000),
        .INHIBIT_US(INH),
        .TIMEOUT_US(TO),
        .FILTER(FILT)
    ) dut (
        .clk(clk), .rst(rst), .k_clk(k_clk), .k_data(k_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .k_clk_oe(k_clk_oe), .k_data_oe(k_data_oe), .busy(busy),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always @(negedge clk) begin
        if (done)    n_done++;
        if (ack_err) n_nack++;
        if (timeout) n_to++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: frame[0]=start seen before first edge, frame[1..10] sampled at rising edges.
    task automatic run_device(input bit ack, input int glitch_at, input bit spurious,
                              input int n_edges, output logic [10:0] frame,
                              output int inh_only, output int inh_total);
        int guard;
        frame = '0; inh_only = 0; inh_total = 0; guard = 0;
        if (spurious) begin
            tx_data  = 8'h99;
            tx_valid = 1'b1;
        end
        while (k_clk_oe && guard < 500) begin
            inh_total++;
            if (!k_data_oe) inh_only++;
            @(negedge clk);
            guard++;
        end
        tx_valid = 1'b0;
        chk("release_wait", 32'(guard < 500), 32'd1);
        repeat (30) @(negedge clk);
        frame[0] = k_data;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) frame[e] = k_data;
            if (e == glitch_at) begin
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (FILT - 1) @(negedge clk);
                dev_clk_low = 1'b0;
            end
            repeat (H) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic do_vector(input string tag, input vec_t v, input int glitch_at, input bit spurious);
        logic [10:0] frame;
        int inh_only, inh_total, d0, k0, t0;
        d0 = n_done; k0 = n_nack; t0 = n_to;
        start_tx(v.data);
        run_device(v.ack, glitch_at, spurious, 11, frame, inh_only, inh_total);
        repeat (40) @(negedge clk);
        chk({tag, "_frame"}, 32'(frame), 32'({1'b1, v.exp_par, v.data, 1'b0}));
        chk({tag, "_inhibit"}, 32'(inh_only), 32'(INH));
        chk({tag, "_clk_low"}, 32'(inh_total), 32'(INH + 16));
        chk({tag, "_done"}, 32'(n_done - d0), 32'(v.exp_done));
        chk({tag, "_ack_err"}, 32'(n_nack - k0), 32'(v.exp_nack));
        chk({tag, "_timeout"}, 32'(n_to - t0), 32'd0);
        chk({tag, "_idle"}, {30'd0, tx_ready, busy}, 32'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, t0;
        logic [10:0] frame;
        int inh_only, inh_total;
        vec_t v;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1, 0};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 0, 1};

        tx_data = '0; tx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {25'd0, tx_ready, busy, k_clk_oe, k_data_oe, done, ack_err, timeout},
            32'b1000000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) do_vector($sformatf("vec%0d", i), vecs[i], 0, 1'b0);

        // Device never clocks: timeout counted from the cycle k_clk is released.
        t0 = n_to; d0 = n_done;
        start_tx(8'h42);
        n = 0;
        while (k_clk_oe && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (!timeout && n < TO + 50) begin @(negedge clk); n++; end
        chk("to_latency", 32'(n), 32'(TO));
        chk("to_lines", {30'd0, k_clk_oe, k_data_oe}, 32'd0);
        @(negedge clk);
        chk("to_ready", {30'd0, tx_ready, busy}, 32'b10);
        chk("to_count", 32'(n_to - t0), 32'd1);
        chk("to_no_done", 32'(n_done - d0), 32'd0);

        // Async reset while inhibiting, then while shifting bit 4 of 0xA5.
        start_tx(8'hA5);
        repeat (5) @(negedge clk);
        chk("inh_clk_oe", 32'(k_clk_oe), 32'd1);
        #2 rst = 1'b0;
        #1 chk("rst_inh_lines", {30'd0, k_clk_oe, k_data_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        start_tx(8'hA5);
        run_device(1'b1, 0, 1'b0, 4, frame, inh_only, inh_total);
        chk("a5_bits_0to3", 32'(frame[4:0]), 32'b01010);
        chk("a5_bit3_oe", 32'(k_data_oe), 32'd1);
        #2 rst = 1'b0;
        #1 chk("rst_send_lines", {30'd0, k_clk_oe, k_data_oe}, 32'd0);
        chk("rst_send_ready", {30'd0, tx_ready, busy}, 32'b10);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        v = '{8'h3C, 1'b1, 1'b1, 1, 0};
        do_vector("after_rst", v, 0, 1'b0);

        // Sub-filter clock glitch mid-frame and tx_valid held while busy.
        d0 = n_done;
        v = '{8'h5A, 1'b1, 1'b1, 1, 0};
        do_vector("glitch", v, 3, 1'b1);
        repeat (100) @(negedge clk);
        chk("no_queue_busy", 32'(busy), 32'd0);
        chk("no_queue_done", 32'(n_done - d0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
